// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// The fetch unit drives the request side; the memory returns grant and read data.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding request FSM (FETCH -> WAIT -> VALID)
// with branch/jump redirect from decode and a higher-priority external flush.
// A kill flag discards the response of a request that was in flight when a
// flush arrived, so decode never sees a stale instruction.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_if.master        imem,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [6:0]           op_code,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [31:0]          pc_out,
    output logic [31:0]          pc_plus4,
    input  logic                 pc_src,
    input  logic [31:0]          pc_target,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    output logic                 misalign
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        kill;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

    // Request is held low while reset is asserted, even though state is FETCH.
    assign imem.imem_req  = rst_n && (state == FETCH);
    assign imem.imem_addr = pc;

    // pc only advances on consume or redirect, so it names the presented instruction.
    assign instr_valid = (state == VALID);
    assign pc_out      = pc;
    assign pc_plus4    = pc + 32'd4;
    assign op_code     = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];

    // Fetch FSM: flush outranks every other event in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            instr    <= NOP;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                FETCH: begin
                    if (flush) begin
                        pc       <= align_word(flush_pc);
                        misalign <= is_misaligned(flush_pc);
                        // A grant in the flush cycle is already issued; its data must die.
                        if (imem.imem_gnt) begin
                            state <= WAIT;
                            kill  <= 1'b1;
                        end
                    end else if (imem.imem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc       <= align_word(flush_pc);
                        misalign <= is_misaligned(flush_pc);
                        if (imem.imem_rvalid) begin
                            state <= FETCH;
                            kill  <= 1'b0;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end else if (imem.imem_rvalid) begin
                        if (kill) begin
                            state <= FETCH;
                            kill  <= 1'b0;
                        end else begin
                            instr <= imem.imem_rdata;
                            state <= VALID;
                        end
                    end
                end
                VALID: begin
                    if (flush) begin
                        pc       <= align_word(flush_pc);
                        misalign <= is_misaligned(flush_pc);
                        state    <= FETCH;
                    end else if (instr_ready) begin
                        pc       <= pc_src ? align_word(pc_target) : pc_plus4;
                        misalign <= pc_src && is_misaligned(pc_target);
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural memory with configurable latency,
// a pc model and a scoreboard of expected instructions pushed at grant time and
// popped when decode consumes.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc_out, pc_plus4, pc_target, flush_pc;
    logic [6:0]  op_code, funct7;
    logic [2:0]  funct3;
    logic        pc_src, flush, misalign;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op_code     (op_code),
        .funct3      (funct3),
        .funct7      (funct7),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .misalign    (misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    logic [31:0] addr_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          first_valid;
    int          cons_count;
    logic [31:0] last_cons_pc;
    logic [31:0] exp_pc;
    logic        resp_pend;
    int          resp_wait;
    logic [31:0] resp_addr;
    int          mem_lat;
    logic        gnt_en, stale_inj;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h0000_006F;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] align_w(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive memory at the falling edge, score outputs, advance models.
    task automatic cycle();
        logic        pend_n;
        int          wait_n;
        logic [31:0] addr_n, pc_n;
        logic        mis_n, consume, in_rst;
        exp_t        e;
        @(negedge clk);
        in_rst           = !rst_n;
        bus.imem_gnt     = bus.imem_req && gnt_en;
        bus.imem_rvalid  = (resp_pend && resp_wait == 0) || stale_inj;
        bus.imem_rdata   = (resp_pend && resp_wait == 0) ? mem_word(resp_addr) : 32'hBAD0_0BAD;
        pend_n = resp_pend;
        wait_n = resp_wait;
        addr_n = resp_addr;
        pc_n   = exp_pc;
        mis_n  = 1'b0;
        if (resp_pend && resp_wait == 0) pend_n = 1'b0;
        else if (resp_pend) wait_n = resp_wait - 1;
        if (instr_valid) begin
            if (first_valid < 0) first_valid = cyc;
            chk("present_has_expect", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("present_pc", pc_out, q[0].pc);
        end
        consume = instr_valid && instr_ready && !flush;
        if (consume && q.size() != 0) begin
            e = q.pop_front();
            chk("instr",    instr,           e.word);
            chk("pc_out",   pc_out,          e.pc);
            chk("pc_plus4", pc_plus4,        e.pc + 32'd4);
            chk("op_code",  32'(op_code),    32'(e.word[6:0]));
            chk("funct3",   32'(funct3),     32'(e.word[14:12]));
            chk("funct7",   32'(funct7),     32'(e.word[31:25]));
            cons_count++;
            last_cons_pc = pc_out;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            chk("imem_addr", bus.imem_addr, exp_pc);
            pend_n = 1'b1;
            wait_n = mem_lat;
            addr_n = bus.imem_addr;
            addr_log.push_back(bus.imem_addr);
            if (!flush) q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
        end
        if (flush) begin
            q.delete();
            pc_n  = align_w(flush_pc);
            mis_n = |flush_pc[1:0];
        end else if (consume) begin
            pc_n  = pc_src ? align_w(pc_target) : exp_pc + 32'd4;
            mis_n = pc_src && (|pc_target[1:0]);
        end
        @(posedge clk);
        #1;
        if (in_rst) begin
            resp_pend = 1'b0;
        end else begin
            resp_pend = pend_n;
            resp_wait = wait_n;
            resp_addr = addr_n;
            exp_pc    = pc_n;
            chk("misalign_model", 32'(misalign), 32'(mis_n));
        end
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        rst_n = 1'b0; instr_ready = 1'b1; pc_src = 1'b0; pc_target = '0;
        flush = 1'b0; flush_pc = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        resp_pend = 1'b0; resp_wait = 0; resp_addr = '0; mem_lat = 0;
        gnt_en = 1'b1; stale_inj = 1'b0; exp_pc = RESET_PC;
        cyc = 0; first_valid = -1; cons_count = 0; last_cons_pc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      32'(bus.imem_req), 32'd0);
        chk("rst_valid",    32'(instr_valid),  32'd0);
        chk("rst_instr",    instr,             32'h0000_0013);
        chk("rst_misalign", 32'(misalign),     32'd0);
        chk("rst_pc_out",   pc_out,            RESET_PC);
        chk("rst_op_code",  32'(op_code),      32'h13);

        // Sequential fetch, zero-wait memory
        rst_n = 1'b1;
        #1;
        chk("first_req",  32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr,     RESET_PC);
        repeat (9) cycle();
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("seq_count", 32'(cons_count), 32'd3);
        chk("seq_addr0", addr_log[0], 32'h0);
        chk("seq_addr1", addr_log[1], 32'h4);
        chk("seq_addr2", addr_log[2], 32'h8);

        // jal at 0xC redirected to 0x100
        pc_src = 1'b1; pc_target = 32'h100;
        repeat (3) cycle();
        pc_src = 1'b0;
        chk("jal_cons_pc",   last_cons_pc,  32'hC);
        chk("jal_next_addr", bus.imem_addr, 32'h100);
        repeat (3) cycle();
        chk("jal_pc_out", last_cons_pc, 32'h100);

        // Misaligned redirect target
        pc_src = 1'b1; pc_target = 32'h102;
        repeat (3) cycle();
        chk("mis_pulse", 32'(misalign),     32'd1);
        chk("mis_addr",  bus.imem_addr,     32'h100);
        pc_src = 1'b0;
        cycle();
        chk("mis_clear", 32'(misalign), 32'd0);

        // Decode stall for 5 cycles
        instr_ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", 32'(instr_valid),  32'd1);
            chk("stall_req",   32'(bus.imem_req), 32'd0);
            chk("stall_instr", instr,             mem_word(32'h100));
            chk("stall_pc",    pc_out,            32'h100);
        end
        instr_ready = 1'b1;
        cycle();
        chk("stall_cons_pc", last_cons_pc, 32'h100);

        // Flush while waiting on a slow response
        mem_lat = 2;
        cycle();
        flush = 1'b1; flush_pc = 32'h200;
        cycle();
        flush = 1'b0;
        idx = addr_log.size();
        n = cons_count;
        for (int i = 0; i < 20 && cons_count == n; i++) cycle();
        chk("wflush_cons",    32'(cons_count), 32'(n + 1));
        chk("wflush_pc",      last_cons_pc,    32'h200);
        chk("wflush_addr",    (addr_log.size() > idx) ? addr_log[idx] : 32'hFFFF_FFFF, 32'h200);
        mem_lat = 0;

        // Flush in VALID beats a simultaneous consume with pc_src
        repeat (2) cycle();
        flush = 1'b1; flush_pc = 32'h303; pc_src = 1'b1; pc_target = 32'h500;
        cycle();
        flush = 1'b0; pc_src = 1'b0;
        chk("vflush_valid", 32'(instr_valid), 32'd0);
        chk("vflush_addr",  bus.imem_addr,    32'h300);
        chk("vflush_mis",   32'(misalign),    32'd1);
        repeat (3) cycle();
        chk("vflush_cons_pc", last_cons_pc, 32'h300);

        // Flush coinciding with a grant in FETCH
        flush = 1'b1; flush_pc = 32'h400;
        cycle();
        flush = 1'b0;
        chk("fflush_req", 32'(bus.imem_req), 32'd0);
        n = cons_count;
        for (int i = 0; i < 10 && cons_count == n; i++) cycle();
        chk("fflush_cons_pc", last_cons_pc, 32'h400);
        chk("fflush_last_addr", addr_log[addr_log.size() - 1], 32'h400);

        // pc wraps past the top of the address space
        gnt_en = 1'b0; flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        cycle();
        gnt_en = 1'b1; flush = 1'b0;
        repeat (3) cycle();
        chk("wrap_cons_pc", last_cons_pc,  32'hFFFF_FFFC);
        chk("wrap_addr",    bus.imem_addr, 32'h0);

        // Reset during WAIT, then a stale response
        cycle();
        chk("prerst_req", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst2_req",   32'(bus.imem_req), 32'd0);
        chk("rst2_valid", 32'(instr_valid),  32'd0);
        chk("rst2_instr", instr,             32'h0000_0013);
        chk("rst2_pc",    pc_out,            RESET_PC);
        q.delete();
        resp_pend = 1'b0;
        exp_pc = RESET_PC;
        repeat (2) cycle();
        rst_n = 1'b1; gnt_en = 1'b0; stale_inj = 1'b1;
        cycle();
        stale_inj = 1'b0; gnt_en = 1'b1;
        chk("stale_valid", 32'(instr_valid),  32'd0);
        chk("stale_req",   32'(bus.imem_req), 32'd1);
        chk("stale_addr",  bus.imem_addr,     RESET_PC);
        n = cons_count;
        repeat (3) cycle();
        chk("restart_cons", 32'(cons_count), 32'(n + 1));
        chk("restart_pc",   last_cons_pc,    RESET_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address, equals pc while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-007 imem_rvalid  input  1  read data valid, one pulse per granted request.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr_valid  output  1  instruction presented to decode.
REQ-010 instr_ready  input  1  decode consumes the presented instruction this cycle.
REQ-011 instr  output  32  registered instruction word.
REQ-012 op_code  output  7  instr[6:0].
REQ-013 funct3  output  3  instr[14:12].
REQ-014 funct7  output  7  instr[31:25].
REQ-015 pc_out  output  32  address of the presented instruction.
REQ-016 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-017 pc_src  input  1  control-path redirect select for the presented instruction.
REQ-018 pc_target  input  32  branch/jump target from the datapath.
REQ-019 flush  input  1  external redirect, highest priority.
REQ-020 flush_pc  input  32  external redirect address.
REQ-021 misalign  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-022 FSM states: FETCH, WAIT, VALID. At most one imem request is outstanding.
REQ-023 FETCH: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT.
REQ-024 WAIT: imem_req=0. On imem_rvalid with kill=0, latch imem_rdata into instr and go to VALID.
REQ-025 VALID: instr_valid=1, and instr/pc_out stay stable until consumed.
REQ-026 VALID consume condition: instr_valid && instr_ready. On consume, next pc = pc_src ? pc_target : pc_plus4, and the FSM goes to FETCH.
REQ-027 Fetch latency: first imem_req appears in the first cycle after rst_n deasserts. With zero-wait memory (gnt same cycle, rvalid next cycle), instr_valid rises 2 cycles after the request.
REQ-028 Decoded fields (op_code, funct3, funct7) are combinational slices of the instr register only.
REQ-029 Redirect alignment: any redirect address is forced to {addr[31:2],2'b00}. misalign pulses for 1 cycle if addr[1:0] != 0.
REQ-030 flush in FETCH:
  - pc <= flush_pc, state stays FETCH, and imem_req is held.
  - A grant in the same cycle as flush is treated as issued: go to WAIT with kill=1.
REQ-031 flush in WAIT: pc <= flush_pc and kill <= 1. A later rvalid is discarded, kill clears, and the FSM goes to FETCH.
REQ-032 flush in the same cycle as rvalid in WAIT: data is discarded, pc <= flush_pc, FSM goes to FETCH.
REQ-033 flush in VALID: instr_valid drops next cycle, pc <= flush_pc, FSM goes to FETCH. A simultaneous consume is ignored, and flush_pc wins over pc_src.
REQ-034 instr_valid is never asserted in FETCH or WAIT. Decode never sees a killed instruction.
REQ-035 rvalid received while not in WAIT is ignored.
REQ-036 pc arithmetic is 32-bit unsigned and wraps from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-037 While rst_n=0 and immediately on its assertion:
  - pc=RESET_PC, state=FETCH, kill=0
  - instr=32'h0000_0013 (NOP), instr_valid=0, misalign=0
  - imem_req=0 while reset is held
REQ-038 Reset asserted mid-transaction abandons the outstanding request. An rvalid arriving after reset release with no grant issued is ignored.

Verification
REQ-039 Zero-wait memory, RESET_PC=0, instr_ready=1, pc_src=0 -> imem_addr sequence 0x0,0x4,0x8, one instruction per 3 cycles.
REQ-040 Instruction 0x0000006F (jal) presented with pc_src=1, pc_target=0x100 -> next imem_addr=0x100 and pc_out=0x100 on the next valid.
REQ-041 flush=1, flush_pc=0x200 while in WAIT -> returned rdata is never presented, next imem_addr=0x200, instr_valid stays 0 until the 0x200 data arrives.
REQ-042 instr_ready=0 for 5 cycles in VALID -> instr, pc_out, instr_valid stable, imem_req=0 throughout.
REQ-043 pc_src=1, pc_target=0x102 -> imem_addr=0x100, misalign high for exactly 1 cycle.
REQ-044 rst_n pulsed low during WAIT, then memory returns stale rvalid -> ignored, fetch restarts at RESET_PC with instr_valid=0.
